// File: rtl/gate_stim_pkg.sv
// Shared encodings for the 8-input gate stimulus sequencer.
// Mode switches and FSM state share one 2-bit code.
package gate_stim_pkg;

    localparam int GATE_INPUTS = 8;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'b00,
        ST_MANUAL = 2'b01,
        ST_AUTO   = 2'b10,
        ST_LOAD   = 2'b11
    } state_e;

    // Width of the packed {h..a} pattern bus for a given per-input width.
    function automatic int pat_width(input int width);
        return GATE_INPUTS * width;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, counter debounce and a
// registered rising-edge pulse. It stays disarmed until the button is seen released after reset.
module btn_debounce #(
    parameter int DEB_CYCLES = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1_reg, s2_reg;
    logic          level_reg, level_d_reg, rise_reg, armed_reg;
    logic [1:0]    valid_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg      <= 1'b0;
            s2_reg      <= 1'b0;
            valid_reg   <= 2'b00;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            rise_reg    <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            s1_reg      <= btn_raw;
            s2_reg      <= s1_reg;
            valid_reg   <= {valid_reg[0], 1'b1};
            level_d_reg <= level_reg;
            if (s2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= ~level_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            // A button already held through reset must be released before it can step.
            if (valid_reg[1] && !s2_reg && !level_reg) begin
                armed_reg <= 1'b1;
            end
            rise_reg <= level_reg & ~level_d_reg & armed_reg;
        end
    end

    assign btn_level = level_reg;
    assign btn_rise  = rise_reg;

endmodule

// File: rtl/gate_stim_seq.sv
// Stimulus sequencer for the 8-input nandgate: hold, manual step,
// timed auto-sweep and direct switch load of the {h..a} pattern.
module gate_stim_seq
    import gate_stim_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int DEB_CYCLES = 2000000,
    parameter int DIV        = 100000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_step,
    input  logic [1:0]         mode,
    input  logic [8*WIDTH-1:0] sw_pat,
    output logic [8*WIDTH-1:0] pat,
    output logic               pat_upd,
    output logic               wrap,
    output logic [1:0]         state_o
);

    localparam int PW = pat_width(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] PRESC_LAST = DW'(DIV - 1);

    logic [1:0]    mode_s1_reg, mode_s2_reg;
    logic [PW-1:0] sw_sync;
    logic          btn_level, step_pulse;

    state_e        state_reg, state_next;
    logic [PW-1:0] pat_reg, pat_next;
    logic          upd_reg, upd_next;
    logic          wrap_reg, wrap_next;
    logic [DW-1:0] presc_reg, presc_next;
    logic          do_inc;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_step),
        .btn_level(btn_level),
        .btn_rise (step_pulse)
    );

    // Pattern switches are quasi-static: plain per-bit synchronisers.
    for (genvar gi = 0; gi < PW; gi++) begin : g_sw_sync
        logic [1:0] sync_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync_reg <= 2'b00;
            else        sync_reg <= {sync_reg[0], sw_pat[gi]};
        end
        assign sw_sync[gi] = sync_reg[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_reg <= 2'b00;
            mode_s2_reg <= 2'b00;
            state_reg   <= ST_HOLD;
            pat_reg     <= '0;
            upd_reg     <= 1'b0;
            wrap_reg    <= 1'b0;
            presc_reg   <= '0;
        end else begin
            mode_s1_reg <= mode;
            mode_s2_reg <= mode_s1_reg;
            state_reg   <= state_next;
            pat_reg     <= pat_next;
            upd_reg     <= upd_next;
            wrap_reg    <= wrap_next;
            presc_reg   <= presc_next;
        end
    end

    always_comb begin
        state_next = state_e'(mode_s2_reg);
        pat_next   = pat_reg;
        upd_next   = 1'b0;
        wrap_next  = 1'b0;
        presc_next = '0;
        do_inc     = 1'b0;
        unique case (state_reg)
            ST_HOLD: begin
            end
            ST_MANUAL: do_inc = step_pulse && btn_level;
            ST_AUTO: begin
                if (presc_reg == PRESC_LAST) do_inc = 1'b1;
                else                         presc_next = presc_reg + DW'(1);
            end
            ST_LOAD: begin
                pat_next = sw_sync;
                upd_next = (sw_sync != pat_reg);
            end
        endcase
        // Only an increment can wrap; loading zero never flags it.
        if (do_inc) begin
            pat_next  = pat_reg + PW'(1);
            upd_next  = 1'b1;
            wrap_next = &pat_reg;
        end
    end

    assign pat     = pat_reg;
    assign pat_upd = upd_reg;
    assign wrap    = wrap_reg;
    assign state_o = state_reg;

endmodule

// File: tb/tb_gate_stim_seq.sv
// Self-checking bench for gate_stim_seq: scoreboard of expected pattern
// updates plus per-scenario inline checks.
module tb_gate_stim_seq;

    localparam int WIDTH = 1;
    localparam int PW    = 8 * WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_step = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [PW-1:0] sw_pat = '0;
    logic [PW-1:0] pat;
    logic          pat_upd, wrap;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] p;
        logic       w;
    } exp_t;
    exp_t sb[$];

    gate_stim_seq #(.WIDTH(WIDTH), .DEB_CYCLES(4), .DIV(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_step(btn_step),
        .mode    (mode),
        .sw_pat  (sw_pat),
        .pat     (pat),
        .pat_upd (pat_upd),
        .wrap    (wrap),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every pat_upd must match the next expected update.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            checks++;
            if (wrap && !pat_upd) begin
                errors++;
                $display("FAIL wrap_alone wrap=%b pat_upd=%b required pat_upd=1", wrap, pat_upd);
            end
            if (pat_upd) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_upd pat=%h wrap=%b required no update", pat, wrap);
                end else begin
                    e = sb.pop_front();
                    if (pat !== e.p || wrap !== e.w) begin
                        errors++;
                        $display("FAIL sb_upd pat=%h wrap=%b required pat=%h wrap=%b", pat, wrap, e.p, e.w);
                    end else begin
                        $display("upd pat=%h wrap=%b ok", pat, wrap);
                    end
                end
            end
        end
    end

    task automatic ticks(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_upd(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pat_upd && n < max);
    endtask

    task automatic run_count(input int k, output int ups);
        ups = 0;
        repeat (k) begin
            @(negedge clk);
            if (pat_upd) ups++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        sb.delete();
        ticks(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ticks(3);
        checks++;
        if (pat !== 8'h00 || pat_upd !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs pat=%h upd=%b wrap=%b required 00/0/0", pat, pat_upd, wrap);
        end
        checks++;
        if (state_o !== 2'b00) begin
            errors++;
            $display("FAIL reset_state state=%b required 00", state_o);
        end
        rst_n = 1'b1;
        ticks(4);
        checks++;
        if (pat !== 8'h00 || state_o !== 2'b00) begin
            errors++;
            $display("FAIL post_reset pat=%h state=%b required 00/00", pat, state_o);
        end
    endtask

    task automatic test_manual_hold();
        int n;
        mode = 2'b01;
        ticks(6);
        checks++;
        if (state_o !== 2'b01) begin
            errors++;
            $display("FAIL manual_state state=%b required 01", state_o);
        end
        btn_step = 1'b1;
        sb.push_back('{p: 8'h01, w: 1'b0});
        wait_upd(30, n);
        checks++;
        if (n != 8 || pat_upd !== 1'b1) begin
            errors++;
            $display("FAIL btn_latency edges=%0d upd=%b required 8/1", n, pat_upd);
        end
        ticks(20);
        checks++;
        if (pat !== 8'h01) begin
            errors++;
            $display("FAIL held_once pat=%h required 01", pat);
        end
        btn_step = 1'b0;
        ticks(12);
        checks++;
        if (pat !== 8'h01 || sb.size() != 0) begin
            errors++;
            $display("FAIL release_no_step pat=%h pending=%0d required 01/0", pat, sb.size());
        end
    endtask

    task automatic test_bounce();
        int ups = 0;
        for (int i = 0; i < 16; i++) begin
            btn_step = ((i % 4) < 2);
            @(negedge clk);
            if (pat_upd) ups++;
        end
        btn_step = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (pat_upd) ups++;
        end
        checks++;
        if (ups != 0 || pat !== 8'h01) begin
            errors++;
            $display("FAIL bounce ups=%0d pat=%h required 0/01", ups, pat);
        end
    endtask

    task automatic test_auto_sweep();
        int n_upd = 0;
        int last = 0;
        do_reset();
        mode = 2'b10;
        for (int k = 1; k <= 259; k++) begin
            logic [7:0] v;
            v = k[7:0];
            sb.push_back('{p: v, w: (k == 256)});
        end
        for (int c = 1; c <= 1298; c++) begin
            @(negedge clk);
            if (pat_upd) begin
                checks++;
                if (n_upd == 0 && c != 8) begin
                    errors++;
                    $display("FAIL auto_first cycle=%0d required 8", c);
                end else if (n_upd != 0 && c - last != 5) begin
                    errors++;
                    $display("FAIL auto_period gap=%0d required 5", c - last);
                end
                last = c;
                n_upd++;
                if (n_upd == 256) begin
                    checks++;
                    if (pat !== 8'h00 || wrap !== 1'b1) begin
                        errors++;
                        $display("FAIL auto_wrap pat=%h wrap=%b required 00/1", pat, wrap);
                    end
                end
            end
        end
        mode = 2'b00;
        ticks(8);
        checks++;
        if (n_upd != 259 || pat !== 8'h03 || sb.size() != 0) begin
            errors++;
            $display("FAIL auto_total steps=%0d pat=%h pending=%0d required 259/03/0", n_upd, pat, sb.size());
        end
        checks++;
        if (state_o !== 2'b00) begin
            errors++;
            $display("FAIL auto_to_hold state=%b required 00", state_o);
        end
    endtask

    task automatic test_load();
        logic [7:0] vals [3];
        int n;
        vals = '{8'hA5, 8'h00, 8'hA5};
        sw_pat = 8'h03;
        mode = 2'b11;
        ticks(6);
        checks++;
        if (state_o !== 2'b11 || pat !== 8'h03) begin
            errors++;
            $display("FAIL load_enter state=%b pat=%h required 11/03", state_o, pat);
        end
        for (int i = 0; i < 3; i++) begin
            sw_pat = vals[i];
            sb.push_back('{p: vals[i], w: 1'b0});
            wait_upd(10, n);
            checks++;
            if (n != 3 || pat !== vals[i] || wrap !== 1'b0) begin
                errors++;
                $display("FAIL load_val edges=%0d pat=%h wrap=%b required 3/%h/0", n, pat, wrap, vals[i]);
            end
            ticks(3);
        end
        mode = 2'b00;
        ticks(6);
        sw_pat = 8'h3C;
        ticks(10);
        checks++;
        if (pat !== 8'hA5 || state_o !== 2'b00) begin
            errors++;
            $display("FAIL load_hold pat=%h state=%b required a5/00", pat, state_o);
        end
    endtask

    task automatic test_auto_reentry();
        int n, ups;
        mode = 2'b10;
        ticks(3);
        mode = 2'b00;
        run_count(10, ups);
        checks++;
        if (ups != 0 || pat !== 8'hA5) begin
            errors++;
            $display("FAIL reentry_hold ups=%0d pat=%h required 0/a5", ups, pat);
        end
        mode = 2'b10;
        sb.push_back('{p: 8'hA6, w: 1'b0});
        wait_upd(20, n);
        checks++;
        if (n != 8 || pat !== 8'hA6) begin
            errors++;
            $display("FAIL reentry_step edges=%0d pat=%h required 8/a6", n, pat);
        end
        mode = 2'b00;
        run_count(10, ups);
        checks++;
        if (ups != 0 || pat !== 8'hA6) begin
            errors++;
            $display("FAIL reentry_stop ups=%0d pat=%h required 0/a6", ups, pat);
        end
    endtask

    task automatic test_reset_midsweep();
        int n, ups;
        sw_pat = 8'h40;
        mode = 2'b11;
        sb.push_back('{p: 8'h40, w: 1'b0});
        wait_upd(10, n);
        checks++;
        if (pat !== 8'h40) begin
            errors++;
            $display("FAIL preload pat=%h required 40", pat);
        end
        mode = 2'b10;
        btn_step = 1'b1;
        ticks(5);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pat !== 8'h00 || state_o !== 2'b00 || pat_upd !== 1'b0) begin
            errors++;
            $display("FAIL async_reset pat=%h state=%b upd=%b required 00/00/0", pat, state_o, pat_upd);
        end
        mode = 2'b01;
        rst_n = 1'b1;
        run_count(30, ups);
        checks++;
        if (ups != 0 || pat !== 8'h00 || state_o !== 2'b01) begin
            errors++;
            $display("FAIL held_through_reset ups=%0d pat=%h state=%b required 0/00/01", ups, pat, state_o);
        end
        btn_step = 1'b0;
        run_count(12, ups);
        checks++;
        if (ups != 0) begin
            errors++;
            $display("FAIL release_after_reset ups=%0d required 0", ups);
        end
        btn_step = 1'b1;
        sb.push_back('{p: 8'h01, w: 1'b0});
        wait_upd(30, n);
        checks++;
        if (n != 8 || pat !== 8'h01) begin
            errors++;
            $display("FAIL fresh_press edges=%0d pat=%h required 8/01", n, pat);
        end
        btn_step = 1'b0;
        ticks(5);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_manual_hold();
        test_bounce();
        test_auto_sweep();
        test_load();
        test_auto_reentry();
        test_reset_midsweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout sim_time=%0t required finish before 100000", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
